// File: rtl/bus_arbiter_rr_if.sv
// Bus arbitration interface: per-master requests in, one-hot grant and status out.
// The arbiter takes the master modport; requesters (or a bench) drive the slave side.
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 2
);
    localparam int ID_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req;
    logic                 tx_done;
    logic                 prio_mode;
    logic [N_MASTERS-1:0] gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 bus_busy;
    logic                 timeout;
    logic [ID_W-1:0]      timeout_id;
    logic [1:0]           state_show;

    modport master (
        input  req, tx_done, prio_mode,
        output gnt, gnt_id, bus_busy, timeout, timeout_id, state_show
    );

    modport slave (
        output req, tx_done, prio_mode,
        input  gnt, gnt_id, bus_busy, timeout, timeout_id, state_show
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter, fixed-priority or round-robin, holding each grant until
// completion/abort, with a grant-hold watchdog and a one-cycle turnaround after release.
module bus_arbiter_rr #(
    parameter int N_MASTERS = 2,
    parameter int HOLD_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst,
    bus_arbiter_rr_if.master  bus
);
    localparam int ID_W  = $clog2(N_MASTERS);
    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t               r_state;
    logic [N_MASTERS-1:0] r_gnt;
    logic [ID_W-1:0]      r_gnt_id;
    logic                 r_busy;
    logic                 r_timeout;
    logic [ID_W-1:0]      r_timeout_id;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_last;

    logic [ID_W-1:0]      w_win_id;
    logic [ID_W-1:0]      w_idx;
    logic                 w_win_vld;
    logic                 w_abort;
    logic                 w_wd;
    logic                 w_rel;

    // Loops run from the far end so the highest-priority candidate is written last.
    always_comb begin
        w_win_id  = '0;
        w_idx     = '0;
        w_win_vld = |bus.req;
        if (!bus.prio_mode) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                w_idx = ID_W'(i);
                if (bus.req[w_idx]) w_win_id = w_idx;
            end
        end else begin
            for (int i = N_MASTERS; i >= 1; i--) begin
                w_idx = ID_W'((int'(r_last) + i) % N_MASTERS);
                if (bus.req[w_idx]) w_win_id = w_idx;
            end
        end
    end

    // tx_done suppresses the watchdog so a coincident completion is a normal release.
    assign w_abort = !bus.req[r_gnt_id];
    assign w_wd    = (HOLD_MAX != 0) && (r_cnt == HOLD_LAST) && !bus.tx_done;
    assign w_rel   = bus.tx_done || w_abort || w_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_gnt_id     <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
            r_cnt        <= '0;
            r_last       <= ID_W'(N_MASTERS - 1);
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_gnt    <= {{(N_MASTERS-1){1'b0}}, 1'b1} << w_win_id;
                        r_gnt_id <= w_win_id;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_rel) begin
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_busy   <= 1'b0;
                        r_last   <= r_gnt_id;
                        r_cnt    <= '0;
                        r_state  <= S_RELEASE;
                        if (w_wd && !w_abort) begin
                            r_timeout    <= 1'b1;
                            r_timeout_id <= r_gnt_id;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.gnt_id     = r_gnt_id;
    assign bus.bus_busy   = r_busy;
    assign bus.timeout    = r_timeout;
    assign bus.timeout_id = r_timeout_id;
    assign bus.state_show = r_state;
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-master arbiter for the system bus.
- Replaces the fixed two-master arbitration in top.
- Grants exactly one master at a time and holds the grant until the bus reports transaction completion.
- Supports runtime-selectable fixed-priority or round-robin arbitration, plus a grant-hold watchdog that forcibly releases a stuck master.

Parameters:
- N_MASTERS, 2, number of requesting masters; legal range 2..16.
- HOLD_MAX, 64, maximum cycles a grant may be held before forced release; 0 disables the watchdog.
- ID_W, $clog2(N_MASTERS), derived localparam; width of master index outputs.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_MASTERS  per-master bus request; held high by the master for the whole transaction.
- tx_done  input  1  one-cycle pulse from the bus/slave side when the granted transaction completes.
- prio_mode  input  1  0 = fixed priority (index 0 highest); 1 = round robin. Sampled only in IDLE.
- gnt  output  N_MASTERS  one-hot grant; all zero when no master owns the bus.
- gnt_id  output  ID_W  index of the granted master; 0 when gnt is zero.
- bus_busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse on forced release.
- timeout_id  output  ID_W  index of the master last force-released; holds its value until the next timeout or reset.
- state_show  output  2  current state encoding: IDLE=0, GRANT=1, RELEASE=2.

Behaviour:
- Reset: synchronous, evaluated on clk edge with rst=1, and overrides everything, including mid-grant.
  - Outputs after reset: gnt=0, gnt_id=0, bus_busy=0, timeout=0, timeout_id=0, state_show=0.
  - Internal state after reset: hold counter=0, last-grant pointer=N_MASTERS-1, so master 0 wins the first round-robin arbitration.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise compute the winner combinationally.
  - Fixed mode: winner is the lowest set index.
  - RR mode: winner is the first set index searching last+1, last+2, ..., wrapping modulo N_MASTERS.
  - Register gnt, gnt_id and bus_busy=1, and go to GRANT on the same edge.
  - Grant latency: req sampled high at edge k gives gnt high after edge k.
- GRANT:
  - gnt stays stable; the hold counter increments every cycle starting from 0.
  - Release on the first edge where any of these holds:
    - (a) tx_done=1,
    - (b) req[gnt_id]=0 (master abort),
    - (c) HOLD_MAX!=0 and counter==HOLD_MAX-1 and tx_done=0.
  - On release: gnt=0, bus_busy=0, last pointer=gnt_id, counter=0, go to RELEASE.
  - On (c) only: timeout=1 for one cycle and timeout_id=gnt_id.
  - If (a) or (b) coincide with (c), treat as a normal release with no timeout.
- RELEASE:
  - Single bus-turnaround cycle with gnt=0; unconditionally return to IDLE.
  - Requests are not evaluated here, so minimum spacing between grants is 2 idle cycles (RELEASE, then IDLE arbitration edge).
- tx_done outside GRANT is ignored.
- Requests from non-granted masters never affect the current grant; there is no pre-emption.
- prio_mode changes are honoured only at the next IDLE arbitration. The last-grant pointer is updated in both modes.
- A master that keeps req high after release re-competes normally.
  - In RR mode, with other requesters present, it cannot win twice consecutively.
- Invariants (assertions):
  - gnt is one-hot or zero at all times.
  - gnt != 0 iff state==GRANT.
  - gnt_id matches the one-hot gnt.

Test Plan:
- Reset then single request: N_MASTERS=4, assert rst for 2 cycles, req=4'b0100 → gnt=4'b0100 and gnt_id=2 one edge after req. tx_done pulse → gnt=0 next edge, state_show=2 for one cycle, then 0.
- Round-robin fairness: prio_mode=1, req=4'b1111 held, tx_done pulsed 3 cycles into each grant → grant order 0,1,2,3,0; gnt never two-hot.
- Fixed priority starvation: prio_mode=0, req=4'b1010 held, same tx_done pattern → gnt_id=1 on every grant; master 3 is never granted.
- Watchdog: HOLD_MAX=8, req=4'b0001, no tx_done → gnt released after exactly 8 GRANT cycles; timeout=1 for one cycle; timeout_id=0. With HOLD_MAX=0 the grant holds for 100 cycles.
- Abort and coincidence:
  - Drop req[gnt_id] mid-grant → release next edge with timeout=0.
  - tx_done on the counter==HOLD_MAX-1 cycle → release with timeout=0.
- Reset mid-grant: rst=1 while gnt=4'b0010 → after that edge gnt=0 and state_show=0. With req=4'b1111 and prio_mode=1 after reset, the first grant goes to master 0.
